// File: rtl/cpu_pkg.sv
// Shared register-file write-back types and constants.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int N          = 16;
    localparam int SEL_LINE   = 4;
    localparam int NREQ       = 3;
    localparam int REQ_IDX_W  = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam int REQ_ALU    = 0;
    localparam int REQ_LSU    = 1;
    localparam int REQ_MUL    = 2;

    typedef logic [SEL_LINE-1:0]  reg_sel_t;
    typedef logic [N-1:0]         reg_val_t;
    typedef logic [REQ_IDX_W-1:0] req_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starts at ptr_q.
`timescale 1ns/1ps
module rr_arbiter #(
    parameter int NREQ  = 3,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]  req,
    input  logic             enable,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int cand;
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (!found && enable && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Pointer moves past the winner only; an idle or stalled cycle keeps priority.
    always_comb begin
        ptr_d = ptr_q;
        if (found) begin
            if (grant_idx == IDX_W'(NREQ - 1)) ptr_d = '0;
            else                              ptr_d = grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter with busy scoreboard for the issue stage.
`timescale 1ns/1ps
module rf_wb_arbiter
    import cpu_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*SEL_LINE-1:0] req_sel,
    input  logic [NREQ*N-1:0]        req_val,
    input  logic                     stall,
    input  logic                     rsv_valid,
    input  logic [SEL_LINE-1:0]      rsv_sel,
    output logic                     rd_we,
    output logic [SEL_LINE-1:0]      rd_sel,
    output logic [N-1:0]             rd_val,
    output logic [N-1:0]             busy,
    output logic                     wr_unrsv
);

    reg_sel_t         sel_arr [NREQ];
    reg_val_t         val_arr [NREQ];
    logic [NREQ-1:0]  grant;
    req_idx_t         g_idx;
    logic             arb_en;
    logic             xfer;
    reg_sel_t         sel_g;
    reg_val_t         val_g;

    logic             rd_we_q, rd_we_d;
    reg_sel_t         rd_sel_q, rd_sel_d;
    reg_val_t         rd_val_q, rd_val_d;
    logic [N-1:0]     busy_q, busy_d;
    logic             wr_unrsv_q, wr_unrsv_d;

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign sel_arr[i] = req_sel[i*SEL_LINE +: SEL_LINE];
        assign val_arr[i] = req_val[i*N +: N];
    end

    // No grant while reset is held, so nothing appears accepted that will be dropped.
    assign arb_en = ~stall & rst_n;

    rr_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (REQ_IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_valid),
        .enable    (arb_en),
        .grant     (grant),
        .grant_idx (g_idx)
    );

    assign req_ready = grant;
    assign xfer      = |(grant & req_valid);
    assign sel_g     = sel_arr[g_idx];
    assign val_g     = val_arr[g_idx];

    always_comb begin
        rd_we_d    = xfer;
        rd_sel_d   = rd_sel_q;
        rd_val_d   = rd_val_q;
        wr_unrsv_d = 1'b0;
        busy_d     = busy_q;
        if (xfer) begin
            rd_sel_d       = sel_g;
            rd_val_d       = val_g;
            wr_unrsv_d     = ~busy_q[sel_g];
            busy_d[sel_g]  = 1'b0;
        end
        // Applied after the clear so a same-index reservation wins.
        if (rsv_valid) busy_d[rsv_sel] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_we_q    <= 1'b0;
            rd_sel_q   <= '0;
            rd_val_q   <= '0;
            busy_q     <= '0;
            wr_unrsv_q <= 1'b0;
        end else begin
            rd_we_q    <= rd_we_d;
            rd_sel_q   <= rd_sel_d;
            rd_val_q   <= rd_val_d;
            busy_q     <= busy_d;
            wr_unrsv_q <= wr_unrsv_d;
        end
    end

    assign rd_we    = rd_we_q;
    assign rd_sel   = rd_sel_q;
    assign rd_val   = rd_val_q;
    assign busy     = busy_q;
    assign wr_unrsv = wr_unrsv_q;

    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready));
    a_ready_valid : assert property (@(posedge clk) disable iff (!rst_n)
        (req_ready & ~req_valid) == '0);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: expected writes queued at grant, checked at rd_we.
`timescale 1ns/1ps
module tb_rf_wb_arbiter;
    import cpu_pkg::*;

    logic                     clk;
    logic                     rst_n;
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*SEL_LINE-1:0] req_sel;
    logic [NREQ*N-1:0]        req_val;
    logic                     stall;
    logic                     rsv_valid;
    logic [SEL_LINE-1:0]      rsv_sel;
    logic                     rd_we;
    logic [SEL_LINE-1:0]      rd_sel;
    logic [N-1:0]             rd_val;
    logic [N-1:0]             busy;
    logic                     wr_unrsv;

    rf_wb_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sel   (req_sel),
        .req_val   (req_val),
        .stall     (stall),
        .rsv_valid (rsv_valid),
        .rsv_sel   (rsv_sel),
        .rd_we     (rd_we),
        .rd_sel    (rd_sel),
        .rd_val    (rd_val),
        .busy      (busy),
        .wr_unrsv  (wr_unrsv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [SEL_LINE-1:0] sel;
        logic [N-1:0]        val;
    } wr_t;

    int          n_checks;
    int          n_errors;
    wr_t         exp_q[$];
    logic [3:0]  tb_sel [NREQ];
    logic [15:0] tb_val [NREQ];
    logic [15:0] m_busy;
    logic        m_unrsv;
    logic        m_we;
    bit          mon_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] s, input logic [15:0] v);
        tb_sel[i] = s;
        tb_val[i] = v;
        req_sel[i*SEL_LINE +: SEL_LINE] = s;
        req_val[i*N +: N] = v;
    endtask

    // One clock with the current inputs; exp_ready is the grant the spec demands.
    task automatic cycle(input logic [2:0] exp_ready);
        logic [15:0] b_n;
        logic        u_n;
        logic        xf;
        int          g;
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(exp_ready));
        b_n = m_busy;
        u_n = 1'b0;
        xf  = 1'b0;
        g   = 0;
        for (int i = 0; i < NREQ; i++) if (exp_ready[i]) begin xf = 1'b1; g = i; end
        if (xf) begin
            exp_q.push_back('{sel: tb_sel[g], val: tb_val[g]});
            u_n = ~m_busy[tb_sel[g]];
            b_n[tb_sel[g]] = 1'b0;
        end
        if (rsv_valid) b_n[rsv_sel] = 1'b1;
        @(posedge clk);
        #1;
        m_busy  = b_n;
        m_unrsv = u_n;
        m_we    = xf;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            wr_t e;
            check("rd_we", 32'(rd_we), 32'(m_we));
            check("busy", 32'(busy), 32'(m_busy));
            check("wr_unrsv", 32'(wr_unrsv), 32'(m_unrsv));
            if (rd_we) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_sel", 32'(rd_sel), 32'(e.sel));
                    check("rd_val", 32'(rd_val), 32'(e.val));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_errors = 0;
        mon_en = 1'b0; m_busy = '0; m_unrsv = 1'b0; m_we = 1'b0;
        req_sel = '0; req_val = '0;
        rst_n = 1'b0; stall = 1'b0;
        req_valid = 3'b111; rsv_valid = 1'b1; rsv_sel = 4'd5;
        set_req(REQ_ALU, 4'd7, 16'h00A0);
        set_req(REQ_LSU, 4'd8, 16'h00B1);
        set_req(REQ_MUL, 4'd6, 16'h00C2);

        // Reset with everything active.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_we", 32'(rd_we), 32'd0);
        check("rst_rd_sel", 32'(rd_sel), 32'd0);
        check("rst_rd_val", 32'(rd_val), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wr_unrsv", 32'(wr_unrsv), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        cycle(3'b001);
        req_valid = '0; rsv_valid = 1'b0;

        // Single requester to a reserved register.
        rsv_valid = 1'b1; rsv_sel = 4'd5;
        cycle(3'b000);
        rsv_valid = 1'b0;
        set_req(REQ_ALU, 4'd5, 16'h1234);
        req_valid = 3'b001;
        cycle(3'b001);
        req_valid = '0;
        cycle(3'b000);

        // Park ptr at 0 via a MUL grant, then round-robin.
        set_req(REQ_MUL, 4'd3, 16'h0333);
        req_valid = 3'b100;
        cycle(3'b100);
        set_req(REQ_ALU, 4'd10, 16'hA00A);
        set_req(REQ_LSU, 4'd11, 16'hB00B);
        set_req(REQ_MUL, 4'd12, 16'hC00C);
        req_valid = 3'b111;
        for (int r = 0; r < 2; r++) begin
            cycle(3'b001);
            cycle(3'b010);
            cycle(3'b100);
        end
        req_valid = '0;
        cycle(3'b000);

        // Stall with LSU only, then stall with everyone to show ptr held.
        stall = 1'b1; req_valid = 3'b010;
        cycle(3'b000);
        cycle(3'b000);
        stall = 1'b0;
        cycle(3'b010);
        stall = 1'b1; req_valid = 3'b111;
        cycle(3'b000);
        stall = 1'b0;
        cycle(3'b100);
        req_valid = '0;

        // Reservation and write to the same register, then to different ones.
        set_req(REQ_MUL, 4'd3, 16'h3333);
        rsv_valid = 1'b1; rsv_sel = 4'd3; req_valid = 3'b100;
        cycle(3'b100);
        cycle(3'b100);
        rsv_sel = 4'd4;
        cycle(3'b100);
        rsv_valid = 1'b0; req_valid = '0;
        cycle(3'b000);

        // Unreserved write, then reset while rd_we is high and a grant is live.
        set_req(REQ_LSU, 4'd9, 16'hBEEF);
        req_valid = 3'b010;
        cycle(3'b010);
        set_req(REQ_ALU, 4'd4, 16'h4444);
        req_valid = 3'b001;
        @(negedge clk);
        check("mid_ready", 32'(req_ready), 32'b001);
        #2;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check("mid_rd_we", 32'(rd_we), 32'd0);
        check("mid_rd_sel", 32'(rd_sel), 32'd0);
        check("mid_rd_val", 32'(rd_val), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_wr_unrsv", 32'(wr_unrsv), 32'd0);
        check("mid_ready_rst", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("drop_rd_we", 32'(rd_we), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        m_busy = '0; m_unrsv = 1'b0; m_we = 1'b0;
        mon_en = 1'b1;
        set_req(REQ_LSU, 4'd8, 16'h0808);
        set_req(REQ_MUL, 4'd2, 16'h0202);
        req_valid = 3'b111;
        cycle(3'b001);
        req_valid = '0;
        cycle(3'b000);
        cycle(3'b000);
        mon_en = 1'b0;
        check("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 16×16-bit register file. It shares the register file's single write port (`rd_sel`/`rd_val`, decoded by `rd_demux`) among the ALU, load/store unit and multiplier using round-robin arbitration with valid/ready handshakes. It also tracks pending destination registers in a busy scoreboard for the issue stage. It sits between the execute units and `rd_demux`.

## Interface
- `N`, 16: data width and register count
- `SEL_LINE`, 4: register select width
- `NREQ`, 3: number of write-back requesters
- `clk` in 1: clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `req_valid` in NREQ: requester i has a write pending
- `req_ready` out NREQ: requester i granted this cycle (combinational)
- `req_sel` in NREQ*SEL_LINE: destination register, slice i
- `req_val` in NREQ*N: write data, slice i
- `stall` in 1: block all grants this cycle
- `rsv_valid` in 1: issue stage reserves a destination
- `rsv_sel` in SEL_LINE: register being reserved
- `rd_we` out 1: write enable to register file (registered)
- `rd_sel` out SEL_LINE: write select to `rd_demux` (registered)
- `rd_val` out N: write data to `rd_demux` (registered)
- `busy` out N: scoreboard, bit r = write to register r outstanding
- `wr_unrsv` out 1: one-cycle pulse, committed write hit a non-busy register

## Operation
**Arbitration**
- Round-robin pointer `ptr` ∈ [0, NREQ-1].
- Each cycle, if `stall`=0, grant the first requester with `req_valid`=1, searching ptr, ptr+1, … with wrap mod NREQ.
- `req_ready` is one-hot on the granted requester and zero otherwise. With `stall`=1 or no valid requester, `req_ready`=0.
- A transfer occurs when `req_valid[i]` & `req_ready[i]`. The requester must hold `req_sel`/`req_val` stable while valid and not ready.
- After granting g, ptr ← (g+1) mod NREQ. ptr is unchanged when nothing is granted.

**Write port**
- On a transfer: `rd_we`←1, `rd_sel`←`req_sel[g]`, `rd_val`←`req_val[g]`.
- Otherwise: `rd_we`←0, and `rd_sel`/`rd_val` hold their last values.

**Scoreboard**
- `rsv_valid` sets `busy[rsv_sel]` at the clock edge.
- A transfer clears `busy[req_sel[g]]` at the same edge the output registers load.
- If a set and a clear target the same index in the same cycle, the set wins and the bit stays 1.
- Sets and clears to different indices apply independently.
- `wr_unrsv` ← 1 for one cycle when a transfer targets a register whose `busy` bit was 0 (sampled pre-edge, ignoring a same-cycle set). The write still commits.

**Reset**
- Asynchronous `rst_n`=0 clears `rd_we`, `rd_sel`, `rd_val`, `busy`, `wr_unrsv`, and `ptr` to 0.
- A write in flight when reset asserts is dropped.

## Timing
- Grant is combinational, in the same cycle as valid.
- Register-file write data appears at the outputs 1 cycle after the transfer edge. Latency is 1.
- Throughput: 1 write per cycle aggregate. Each requester is guaranteed a grant within NREQ cycles of asserting valid, provided `stall` is low.
- `busy` reflects a reservation or clear 1 cycle after the causing edge.
- `stall` acts on the same cycle; the output register shows `rd_we`=0 the next cycle.
- Reset deassertion: the first grant is possible on the first rising edge with `rst_n`=1. `ptr` starts at 0, so requester 0 has first priority.

## Structure
- Shared package `cpu_pkg`:
  - `N`, `SEL_LINE`, `NREQ`.
  - Requester indices `REQ_ALU`=0, `REQ_LSU`=1, `REQ_MUL`=2.
  - Typedefs `reg_sel_t` (SEL_LINE bits) and `reg_val_t` (N bits).
- Sub-module `rr_arbiter`, parameterised on NREQ. Inputs: req, enable. Outputs: one-hot grant, grant index. It owns `ptr`.
- The top level holds the output registers, the scoreboard and `wr_unrsv`.

## Test plan
- **Reset values:** reset with all inputs active. Outputs = 0 and `busy`=0x0000 until release; first grant goes to requester 0.
- **Single requester:** `rsv_sel`=5 reserved, then ALU valid with sel=5, val=0x1234. Responses:
  - `req_ready[0]` same cycle.
  - Next cycle: `rd_we`=1, `rd_sel`=5, `rd_val`=0x1234.
  - `busy[5]` 1→0; `wr_unrsv`=0.
- **Round-robin fairness:** all three requesters valid for 6 cycles. Grant order 0,1,2,0,1,2; `rd_we` high for 6 consecutive cycles.
- **Stall:** `stall`=1 with LSU valid. `req_ready`=0, `rd_we`=0 and ptr unchanged. On deassert, LSU is granted within 1 cycle.
- **Same-cycle set/clear:** `rsv_sel`=3 reserve coincides with a MUL write to reg 3. `busy[3]` remains 1.
- **Unreserved write plus reset mid-transfer:**
  - Write to reg 9 with `busy[9]`=0: `wr_unrsv` pulses 1 cycle and `rd_we`=1.
  - Assert `rst_n`=0 mid-cycle during a grant: outputs and `busy` go to 0 immediately.
